// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle ripple adder. Adds two WIDTH-bit operands plus a carry-in,
// CHUNK bits per clock. The carry between chunks is kept in a register, so
// the critical path is one CHUNK-bit add instead of a full WIDTH-bit ripple.
// Intended as a datapath slave under a sequencer using a start/busy/done
// handshake.
//
// Parameters
//   WIDTH  operand and sum width (must be an integer multiple of CHUNK)
//   CHUNK  bits added per cycle (CHUNK == WIDTH gives a single-cycle add)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, priority over all inputs
//   start  in   request, only sampled while idle
//   a, b   in   operands, captured on an accepted start
//   c0     in   carry-in, captured on an accepted start
//   sub    in   (only with SEQ_CHUNK_ADDER_SUB_EN) 1 = a - b - c0
//   busy   out  high while an operation is running (RUN and DONE states)
//   done   out  one-cycle pulse; sum/cout/ovf valid from this cycle on
//   sum    out  registered result, modulo 2^WIDTH
//   cout   out  carry out of bit WIDTH-1 ("no borrow" when subtracting)
//   ovf    out  two's-complement overflow (carry into MSB ^ carry out of MSB)
//
// Build option
//   `define SEQ_CHUNK_ADDER_SUB_EN adds the sub port. With sub=1 the captured
//   B operand is ~b and the initial carry is ~c0, so c0 acts as an
//   active-high borrow-in. Without the macro the block is add-only.
//
// Timing: start accepted at edge t -> NCH RUN cycles -> one DONE cycle that
// loads the result registers -> done is high in the cycle after edge
// t+NCH+1. Outputs change only on that load and are held otherwise.
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand / carry capture registers and the partial-sum accumulator.
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             carry_p0;
  logic             msb_cin_p0;
  logic [WIDTH-1:0] part_p0;
  logic [IW-1:0]    idx_p0;

  // Values presented to the capture registers on an accepted start.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Per-cycle chunk arithmetic.
  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_nxt;
  logic             msb_cin;
  logic             last_chunk;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  // Subtraction as a + ~b + ~c0: with c0 as borrow-in this is a - b - c0.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~c0 : c0;
`else
  assign b_eff = b;
  assign c_eff = c0;
`endif

  assign busy       = (state == RUN) || (state == DONE);
  assign last_chunk = (idx_p0 == LAST_IDX);

  always_comb begin
    base    = BW'(int'(idx_p0) * CHUNK);
    a_chunk = a_p0[base +: CHUNK];
    b_chunk = b_p0[base +: CHUNK];
    {c_nxt, s_chunk} = add_chunk(a_chunk, b_chunk, carry_p0);
    // The carry into the chunk MSB falls out of the MSB sum bit:
    // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. Only used on the last chunk.
    msb_cin = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture on start, then one chunk per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_p0       <= '0;
      b_p0       <= '0;
      carry_p0   <= 1'b0;
      msb_cin_p0 <= 1'b0;
      part_p0    <= '0;
      idx_p0     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_p0     <= a;
            b_p0     <= b_eff;
            carry_p0 <= c_eff;
            idx_p0   <= '0;
          end
        end
        RUN: begin
          part_p0[base +: CHUNK] <= s_chunk;
          carry_p0               <= c_nxt;
          if (last_chunk) msb_cin_p0 <= msb_cin;
          idx_p0 <= idx_p0 + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Stage p1: result registers, loaded only from DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        sum  <= part_p0;
        cout <= carry_p0;
        ovf  <= msb_cin_p0 ^ carry_p0;
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, c0, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start8, c08, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c0(c0),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c0(c08),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    res_t        r;
  } vec_t;

  res_t        exp_q[$];
  res_t        mon_r;
  int          nvec = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  logic [15:0] held_sum = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Independent reference: full-width add, overflow from operand/result signs.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic s);
    logic [15:0] yy;
    logic        cc;
    logic [16:0] t;
    res_t        r;
    yy   = s ? ~y : y;
    cc   = s ? ~ci : ci;
    t    = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
    r.s  = t[15:0];
    r.co = t[16];
    r.ov = (x[15] == yy[15]) && (t[15] != x[15]);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(mon_r.s));
        chk("cout", 32'(cout), 32'(mon_r.co));
        chk("ovf", 32'(ovf), 32'(mon_r.ov));
        held_sum = mon_r.s;
      end
    end
  end

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is, input res_t e);
    int lat;
    lat = -1;
    exp_q.push_back(e);
    @(negedge clk);
    a = ia; b = ib; c0 = ic; sub = is; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs after acceptance; the result must not change.
    a = ~ia; b = 16'($urandom); c0 = ~ic; sub = ~is;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      chk("busy during op", 32'(busy), 32'd1);
      chk("sum held", 32'(sum), 32'(held_sum));
    end
    if (lat < 0) begin
      chk("done timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(lat), 32'd5);
      chk("busy at done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done one cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    lat = -1;
    @(negedge clk);
    a8 = ia; b8 = ib; c08 = ic; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
      chk("w8 busy", 32'(busy8), 32'd1);
    end
    if (lat < 0) begin
      chk("w8 done timeout", 32'd0, 32'd1);
    end else begin
      chk("w8 latency", 32'(lat), 32'd2);
      chk("w8 sum", 32'(sum8), 32'(es));
      chk("w8 cout", 32'(cout8), 32'(eco));
      chk("w8 ovf", 32'(ovf8), 32'(eov));
    end
  endtask

  vec_t vt[12];
  res_t er;
  int   d0;

  initial begin
    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vt[2]  = '{16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0}};
    vt[3]  = '{16'h0F0F, 16'h00F1, 1'b0, '{16'h1000, 1'b0, 1'b0}};
    vt[4]  = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
    vt[6]  = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0}};
    vt[7]  = '{16'h4000, 16'h4000, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vt[8]  = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1}};
    vt[9]  = '{16'hA5A5, 16'h5A5A, 1'b0, '{16'hFFFF, 1'b0, 1'b0}};
    vt[10] = '{16'hA5A5, 16'h5A5A, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vt[11] = '{16'h000F, 16'h0001, 1'b0, '{16'h0010, 1'b0, 1'b0}};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c0 = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; c08 = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset busy8", 32'(busy8), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].a, vt[i].b, vt[i].c0, 1'b0, vt[i].r);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // start held high for 12 cycles: exactly two operations.
    er = '{16'h1000, 1'b0, 1'b0};
    exp_q.push_back(er);
    exp_q.push_back(er);
    d0 = done_cnt;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; c0 = 1'b0; sub = 1'b0; start = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("continuous start done count", 32'(done_cnt - d0), 32'd2);
    chk("continuous start queue", 32'(exp_q.size()), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c0 = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    held_sum = 16'h0000;
    repeat (10) @(negedge clk);
    chk("abort no done", 32'(done_cnt - d0), 32'd0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0});

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, '{16'h0001, 1'b1, 1'b0});
`endif

    // Single-cycle configuration.
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, clocked successor to the team's 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands plus carry-in. Processes CHUNK bits per cycle, ripple style, and carries between chunks in a register.
- Trades latency for a short critical path.
- Uses a start/busy/done handshake and sits as a datapath slave under a sequencer.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; CHUNK = WIDTH gives a single-cycle adder.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- c0  in  1  carry-in; captured on an accepted start.
- busy  out  1  high while an operation is in progress (RUN and DONE states).
- done  out  1  one-cycle pulse; the result is valid from this cycle on.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- NCH = WIDTH/CHUNK. Chunk index counter width = clog2(NCH), minimum 1 bit.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal operand/carry/index registers = 0. rst has priority over every other input.
- States:
  - IDLE: start=1 latches a, b, c0 into internal registers, sets idx=0, moves to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes {carry, part[idx*CHUNK +: CHUNK]} = a_r chunk + b_r chunk + carry. Records carry-in of the MSB position on the last chunk. idx increments. After chunk NCH-1, moves to DONE.
  - DONE: sum<=part, cout<=final carry, ovf<=MSB carry-in XOR final carry, done=1 for this cycle only, then returns to IDLE.
- Latency: start accepted at edge t -> done high in the cycle after edge t+NCH+1. This is NCH+1 cycles after acceptance, measured edge to done-cycle; for 16/4, done is observed 5 cycles after start.
- sum/cout/ovf change only in DONE. They hold their values through IDLE and the next RUN; partial results are never visible.
- start while busy=1 (RUN or DONE) is ignored, not queued.
- Operands changing after acceptance have no effect.
- rst during RUN or DONE: aborts, state=IDLE, all outputs cleared the next cycle, and no done pulse.
- Wrap-around: the sum is modulo 2^WIDTH; cout reports the carry out.
- CHUNK=WIDTH: RUN lasts 1 cycle; the same handshake still applies.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on an accepted start.
  - When sub=1, the internal B becomes ~b and the initial carry becomes ~c0. This computes a - b - borrow_in, with c0 acting as an active-high borrow-in; a - b when c0=0.
  - cout then means "no borrow".
  - ovf uses the same MSB carry rule.
- Undefined: there is no sub port and the block is add-only.

Test Plan:
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, c0=0, start pulse -> done pulse exactly 5 cycles later; sum=0x0000, cout=1, ovf=0; busy high for those 5 cycles.
- a=0x7FFF, b=0x0001, c0=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, c0=1 -> sum=0x5556, cout=0, ovf=0; the previous result stays held until this done.
- start asserted continuously for 12 cycles with a=0x0F0F, b=0x00F1 -> exactly two done pulses, each result 0x1000. start during RUN/DONE must be ignored, so the second operation begins at the first IDLE cycle.
- rst asserted in RUN cycle 2 -> no done pulse, sum=0, cout=0, ovf=0 next cycle. A fresh start afterwards must complete normally.
- WIDTH=8, CHUNK=8: a=0x80, b=0x80, c0=0 -> done 2 cycles after start, sum=0x00, cout=1, ovf=1.
- With SEQ_CHUNK_ADDER_SUB_EN, WIDTH=16/CHUNK=4:
  - sub=1, a=0x0005, b=0x0007, c0=0 -> sum=0xFFFE, cout=0, ovf=0.
  - sub=1, a=0x8000, b=0x0001, c0=0 -> sum=0x7FFF, cout=1, ovf=1.
